// File: rtl/sysid_ext.sv
// System-identification Avalon-MM slave: ID, timestamp, config, scratch and an optional prescaled 64-bit uptime.
// Define SYSID_EXT_UPTIME_EN to build the uptime counter, its snapshot register and CONTROL.
module sysid_ext #(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0001,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
    parameter logic [15:0] VERSION         = 16'h0002,
    parameter int          PRESCALE        = 1,
    parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TS      = 3'd1;
    localparam logic [2:0] ADDR_CONFIG  = 3'd2;
    localparam logic [2:0] ADDR_UP_LO   = 3'd3;
    localparam logic [2:0] ADDR_UP_HI   = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH = 3'd5;
    localparam logic [2:0] ADDR_CONTROL = 3'd6;

`ifdef SYSID_EXT_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("sysid_ext: PRESCALE out of range 1..65535");
        end
    endgenerate

    logic [31:0] scratch_r;
    logic [31:0] rdata_s;
    logic [31:0] readdata_r;
    logic        rvalid_r;

`ifdef SYSID_EXT_UPTIME_EN
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] prescale_r;
    logic [63:0] uptime_r;
    logic [31:0] snap_r;
    logic        freeze_r;
    logic        ctrl_wr_s;
    logic        clear_s;
    logic        tick_s;

    assign ctrl_wr_s = write && (address == ADDR_CONTROL);
    assign clear_s   = ctrl_wr_s && writedata[0];
    assign tick_s    = (prescale_r == PRESCALE_LAST);

    // Prescaler and uptime: clear beats freeze, freeze beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_r <= 16'd0;
            uptime_r   <= 64'd0;
        end else if (clear_s) begin
            prescale_r <= 16'd0;
            uptime_r   <= 64'd0;
        end else if (!freeze_r) begin
            if (tick_s) begin
                prescale_r <= 16'd0;
                uptime_r   <= uptime_r + 64'd1;
            end else begin
                prescale_r <= prescale_r + 16'd1;
            end
        end
    end

    // FREEZE bit and the high-word snapshot taken on every UPTIME_LO read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freeze_r <= 1'b0;
            snap_r   <= 32'd0;
        end else begin
            if (ctrl_wr_s) begin
                freeze_r <= writedata[1];
            end
            if (read && (address == ADDR_UP_LO)) begin
                snap_r <= uptime_r[63:32];
            end
        end
    end
`endif

    // Scratch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_r <= SCRATCH_RESET;
        end else if (write && (address == ADDR_SCRATCH)) begin
            scratch_r <= writedata;
        end
    end

    // Read mux; sees pre-write state so a same-cycle read returns the old value.
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            ADDR_ID:      rdata_s = ID_VALUE;
            ADDR_TS:      rdata_s = TIMESTAMP_VALUE;
            ADDR_CONFIG:  rdata_s = {VERSION, 15'd0, UPTIME_PRESENT};
`ifdef SYSID_EXT_UPTIME_EN
            ADDR_UP_LO:   rdata_s = uptime_r[31:0];
            ADDR_UP_HI:   rdata_s = snap_r;
            ADDR_CONTROL: rdata_s = {30'd0, freeze_r, 1'b0};
`endif
            ADDR_SCRATCH: rdata_s = scratch_r;
            default:      rdata_s = 32'd0;
        endcase
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'd0;
            rvalid_r   <= 1'b0;
        end else begin
            rvalid_r <= read;
            if (read) begin
                readdata_r <= rdata_s;
            end
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = rvalid_r;

endmodule

// File: tb/tb_sysid_ext.sv
// Directed self-checking bench for sysid_ext; expectations follow SYSID_EXT_UPTIME_EN.
module tb_sysid_ext;

    localparam logic [31:0] ID_V   = 32'hCAFE_0001;
    localparam logic [31:0] TS_V   = 32'h6543_2100;
    localparam logic [31:0] SCR_V  = 32'hA5A5_0F0F;
`ifdef SYSID_EXT_UPTIME_EN
    localparam logic [31:0] CFG_V  = 32'h0002_0001;
`else
    localparam logic [31:0] CFG_V  = 32'h0002_0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_checks   = 0;
    int n_failures = 0;

    sysid_ext #(
        .ID_VALUE        (ID_V),
        .TIMESTAMP_VALUE (TS_V),
        .VERSION         (16'h0002),
        .PRESCALE        (4),
        .SCRATCH_RESET   (SCR_V)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [31:0] e, input string tag);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check_eq({tag, "_valid"}, {63'd0, readdatavalid}, 64'd1);
        check_eq(tag, {32'd0, readdata}, {32'd0, e});
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", {63'd0, readdatavalid}, 64'd0);
        check_eq("rst_data", {32'd0, readdata}, 64'd0);
        reset = 1'b0;

        read_chk(3'd0, ID_V, "id");
        read_chk(3'd1, TS_V, "timestamp");
        read_chk(3'd2, CFG_V, "config");
        @(negedge clk);
        check_eq("valid_idle", {63'd0, readdatavalid}, 64'd0);
        check_eq("data_hold", {32'd0, readdata}, {32'd0, CFG_V});

        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd2, 32'hFFFF_FFFF);
        read_chk(3'd0, ID_V, "ro_id");
        read_chk(3'd2, CFG_V, "ro_config");
        read_chk(3'd5, SCR_V, "scratch_rst");

        bus_write(3'd5, 32'hDEAD_BEEF);
        address = 3'd5; writedata = 32'h1234_5678; read = 1'b1; write = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check_eq("rw_old_valid", {63'd0, readdatavalid}, 64'd1);
        check_eq("rw_old", {32'd0, readdata}, 64'h0000_0000_DEAD_BEEF);
        read_chk(3'd5, 32'h1234_5678, "rw_new");

        bus_write(3'd7, 32'h5555_AAAA);
        read_chk(3'd7, 32'd0, "addr7");

`ifdef SYSID_EXT_UPTIME_EN
        // Clear at edge C; ticks land on C+4k; the read sampled at C+41 sees 10.
        bus_write(3'd6, 32'd1);
        repeat (40) @(negedge clk);
        read_chk(3'd3, 32'd10, "lo_prescale");

        // Park the counter one tick before the 32-bit carry.
        force dut.uptime_r   = 64'h0000_0000_FFFF_FFFF;
        force dut.prescale_r = 16'd3;
        #1;
        release dut.uptime_r;
        release dut.prescale_r;
        read_chk(3'd3, 32'hFFFF_FFFF, "lo_at_carry");
        read_chk(3'd4, 32'd0, "hi_snap_at_carry");
        read_chk(3'd3, 32'd0, "lo_after_carry");
        read_chk(3'd4, 32'd1, "hi_after_carry");

        // Clear+freeze, release, count to 2 then freeze there.
        bus_write(3'd6, 32'd3);
        bus_write(3'd6, 32'd0);
        repeat (6) @(negedge clk);
        read_chk(3'd3, 32'd1, "lo_count");
        bus_write(3'd6, 32'd2);
        repeat (100) @(negedge clk);
        read_chk(3'd3, 32'd2, "lo_frozen");
        read_chk(3'd6, 32'd2, "ctrl_freeze");
        bus_write(3'd6, 32'd1);
        read_chk(3'd3, 32'd0, "lo_clear");
        read_chk(3'd6, 32'd0, "ctrl_unfrozen");
        repeat (7) @(negedge clk);
        read_chk(3'd3, 32'd2, "lo_resume");
`else
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_write(3'd6, 32'h0000_0003);
        read_chk(3'd3, 32'd0, "lo_absent");
        read_chk(3'd4, 32'd0, "hi_absent");
        read_chk(3'd6, 32'd0, "ctrl_absent");
`endif

        // Reset landing while a read response is valid drops it at once.
        address = 3'd5; read = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rd_valid", {63'd0, readdatavalid}, 64'd1);
        check_eq("mid_rd_data", {32'd0, readdata}, 64'h0000_0000_1234_5678);
        reset = 1'b1; read = 1'b0;
        #1;
        check_eq("rst_drop_valid", {63'd0, readdatavalid}, 64'd0);
        check_eq("rst_drop_data", {32'd0, readdata}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        read_chk(3'd5, SCR_V, "scratch_rst2");
`ifdef SYSID_EXT_UPTIME_EN
        read_chk(3'd4, 32'd0, "hi_rst");
        read_chk(3'd6, 32'd0, "ctrl_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
